// File: rtl/mem_arbiter_fsm.sv
// mem_arbiter_fsm: arbitrates I/D cache misses onto one pipelined memory port,
// sequencing block fills and single-word write-through stores.
module mem_arbiter_fsm #(
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT       = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_req_i,
  input  logic [15:0]                        i_addr_i,
  input  logic                               d_req_i,
  input  logic                               d_we_i,
  input  logic [15:0]                        d_addr_i,
  input  logic [15:0]                        d_wdata_i,
  output logic [15:0]                        fill_data_o,
  output logic [$clog2(WORDS_PER_BLK)-1:0]   fill_word_o,
  output logic                               i_fill_valid_o,
  output logic                               d_fill_valid_o,
  output logic                               i_done_o,
  output logic                               d_done_o,
  output logic                               mem_en_o,
  output logic                               mem_wr_o,
  output logic [15:0]                        mem_addr_o,
  output logic [15:0]                        mem_wdata_o,
  input  logic [15:0]                        mem_rdata_i,
  input  logic                               mem_rvalid_i,
  output logic                               busy_o
);
  localparam int CW = $clog2(WORDS_PER_BLK) + 1;
  localparam int WW = $clog2(MEM_LAT) + 1;
  localparam logic [15:0] BLK_MASK = 16'(2 * WORDS_PER_BLK - 1);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic gnt_d_q, gnt_d_d;
  logic [15:0] base_q, base_d;
  logic [CW-1:0] issue_q, issue_d, recv_q, recv_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [15:0] fill_data_d, mem_addr_d, mem_wdata_d;
  logic [CW-2:0] fill_word_d;
  logic i_fv_d, d_fv_d, i_done_d, d_done_d, mem_en_d, mem_wr_d, busy_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      gnt_d_q        <= 1'b0;
      base_q         <= '0;
      issue_q        <= '0;
      recv_q         <= '0;
      wait_q         <= '0;
      fill_data_o    <= '0;
      fill_word_o    <= '0;
      i_fill_valid_o <= 1'b0;
      d_fill_valid_o <= 1'b0;
      i_done_o       <= 1'b0;
      d_done_o       <= 1'b0;
      mem_en_o       <= 1'b0;
      mem_wr_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_d_q        <= gnt_d_d;
      base_q         <= base_d;
      issue_q        <= issue_d;
      recv_q         <= recv_d;
      wait_q         <= wait_d;
      fill_data_o    <= fill_data_d;
      fill_word_o    <= fill_word_d;
      i_fill_valid_o <= i_fv_d;
      d_fill_valid_o <= d_fv_d;
      i_done_o       <= i_done_d;
      d_done_o       <= d_done_d;
      mem_en_o       <= mem_en_d;
      mem_wr_o       <= mem_wr_d;
      mem_addr_o     <= mem_addr_d;
      mem_wdata_o    <= mem_wdata_d;
      busy_o         <= busy_d;
    end
  end
  // Outputs are computed one cycle ahead so the first access lands in the cycle after grant.
  always_comb begin
    state_d     = state_q;
    gnt_d_d     = gnt_d_q;
    base_d      = base_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    wait_d      = wait_q;
    fill_data_d = '0;
    fill_word_d = '0;
    i_fv_d      = 1'b0;
    d_fv_d      = 1'b0;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      IDLE: if (d_req_i || i_req_i) begin
        gnt_d_d  = d_req_i;
        mem_en_d = 1'b1;
        if (d_req_i && d_we_i) begin
          state_d     = WRITE;
          mem_wr_d    = 1'b1;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          wait_d      = '0;
        end else begin
          state_d    = FILL;
          base_d     = (d_req_i ? d_addr_i : i_addr_i) & ~BLK_MASK;
          mem_addr_d = base_d;
          issue_d    = CW'(1);
          recv_d     = '0;
        end
      end
      FILL: begin
        if (issue_q != CW'(WORDS_PER_BLK)) begin
          mem_en_d   = 1'b1;
          mem_addr_d = base_q + 16'({issue_q, 1'b0});
          issue_d    = issue_q + CW'(1);
        end
        if (mem_rvalid_i) begin
          fill_data_d = mem_rdata_i;
          fill_word_d = recv_q[CW-2:0];
          i_fv_d      = ~gnt_d_q;
          d_fv_d      = gnt_d_q;
          recv_d      = recv_q + CW'(1);
          if (recv_q == CW'(WORDS_PER_BLK - 1)) begin
            state_d  = DONE;
            i_done_d = ~gnt_d_q;
            d_done_d = gnt_d_q;
          end
        end
      end
      WRITE: if (wait_q == WW'(MEM_LAT - 1)) begin
        state_d  = DONE;
        d_done_d = 1'b1;
      end else begin
        wait_d = wait_q + WW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Busy spans the DONE cycle plus one, covering the requester's drop window.
    busy_d = (state_d != IDLE) || (state_q != IDLE);
  end
endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// tb_mem_arbiter_fsm: directed table, hand sequences and random traffic checked
// cycle by cycle against a transaction-timeline model of the arbiter.
module tb_mem_arbiter_fsm;
  localparam int LAT = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] fill_word;
  logic i_fill_valid, d_fill_valid, i_done, d_done, mem_en, mem_wr, mem_rvalid, busy;
  logic spur = 1'b0;
  logic [15:0] spur_d = '0;
  logic [LAT-1:0] pv = '0;
  logic [15:0] pa [LAT];
  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;

  mem_arbiter_fsm #(.WORDS_PER_BLK(8), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .fill_data_o(fill_data), .fill_word_o(fill_word),
    .i_fill_valid_o(i_fill_valid), .d_fill_valid_o(d_fill_valid),
    .i_done_o(i_done), .d_done_o(d_done),
    .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .busy_o(busy)
  );

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Memory: every read returns exactly LAT cycles after its issue cycle.
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], (mem_en === 1'b1) && (mem_wr === 1'b0)};
    pa[0] <= mem_addr;
    for (int k = 1; k < LAT; k++) pa[k] <= pa[k-1];
  end
  assign mem_rvalid = pv[LAT-1] | spur;
  assign mem_rdata  = spur ? spur_d : mdata(pa[LAT-1]);

  typedef struct packed {
    logic busy, en, wr, ifv, dfv, idn, ddn;
    logic [15:0] addr, wdata, fdata;
    logic [2:0] fword;
  } obs_t;
  typedef struct {
    bit v; int g; bit fill; bit dsel; logic [15:0] addr; logic [15:0] wdata; int dk;
  } txn_t;
  typedef struct {
    bit ireq, dreq, dwe; logic [15:0] iaddr, daddr, wdata;
    int e_first_addr, e_first_wr, e_ddone, e_idone, e_nfi, e_nfd, e_blow;
  } vec_t;

  txn_t cur, prev;
  obs_t obs;
  vec_t tbl [5];

  // What one transaction granted in cycle t.g drives in cycle c.
  function automatic obs_t contrib(input txn_t t, input int c);
    obs_t o;
    int k;
    o = '0;
    if (!t.v) return o;
    k = c - t.g;
    o.busy = k >= 1 && k <= t.dk + 1;
    if (t.fill) begin
      if (k >= 1 && k <= 8) begin
        o.en = 1'b1;
        o.addr = t.addr + 16'(2 * (k - 1));
      end
      if (k >= 6 && k <= 13) begin
        o.ifv = !t.dsel;
        o.dfv = t.dsel;
        o.fword = 3'(k - 6);
        o.fdata = mdata(t.addr + 16'(2 * (k - 6)));
      end
      if (k == 13) begin
        o.idn = !t.dsel;
        o.ddn = t.dsel;
      end
    end else begin
      if (k == 1) begin
        o.en = 1'b1; o.wr = 1'b1; o.addr = t.addr; o.wdata = t.wdata;
      end
      o.ddn = (k == 5);
    end
    return o;
  endfunction

  function automatic bit in_fill(input txn_t t, input int c);
    return t.v && t.fill && c >= t.g + 1 && c <= t.g + 12;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sample and check the current cycle, update the model, advance to just after the next edge.
  task automatic tick();
    obs_t e;
    @(negedge clk);
    obs = {busy, mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done,
           mem_en ? mem_addr : 16'h0, (mem_en && mem_wr) ? mem_wdata : 16'h0,
           (i_fill_valid || d_fill_valid) ? fill_data : 16'h0,
           (i_fill_valid || d_fill_valid) ? fill_word : 3'h0};
    e = obs_t'(contrib(cur, cyc) | contrib(prev, cyc));
    cmp($sformatf("cycle %0d outputs", cyc), 64'(obs), 64'(e));
    if (!rst_n) begin
      cur.v = 1'b0;
      prev.v = 1'b0;
    end else if ((!cur.v || cyc > cur.g + cur.dk) && (d_req || i_req)) begin
      prev = cur;
      cur.v = 1'b1;
      cur.g = cyc;
      cur.dsel = d_req;
      cur.fill = !(d_req && d_we);
      cur.addr = (d_req && d_we) ? d_addr : ((d_req ? d_addr : i_addr) & 16'hFFF0);
      cur.wdata = d_wdata;
      cur.dk = cur.fill ? 13 : 5;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int t0, rel, first_addr, first_wr, ddone_at, idone_at, nfi, nfd, blow, cnt;
    bit seen_busy;
    cur = '{default: 0};
    prev = '{default: 0};
    tbl[0] = '{1, 0, 0, 16'h1236, 16'h0, 16'h0,    16'h1230, 0, -1, 13, 8, 0, 15};
    tbl[1] = '{0, 1, 1, 16'h0, 16'h0040, 16'hBEEF, 16'h0040, 1, 5, -1, 0, 0, 7};
    tbl[2] = '{1, 1, 0, 16'h1236, 16'h2000, 16'h0,  16'h2000, 0, 13, 27, 8, 8, 29};
    // D store with I pending: D held through its DONE cycle must not be re-granted.
    tbl[3] = '{1, 1, 1, 16'h00FF, 16'h0102, 16'h1234, 16'h0102, 1, 5, 19, 8, 0, 21};
    tbl[4] = '{0, 1, 0, 16'h0, 16'hFFFE, 16'h0,    16'hFFF0, 0, 13, -1, 0, 8, 15};
    @(posedge clk);
    cyc = 1;
    #1;
    tick();
    cmp("reset outputs", 64'(obs), 64'h0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 5; v++) begin
      i_req = tbl[v].ireq; i_addr = tbl[v].iaddr;
      d_req = tbl[v].dreq; d_we = tbl[v].dwe; d_addr = tbl[v].daddr; d_wdata = tbl[v].wdata;
      t0 = cyc;
      first_addr = -1; first_wr = -1; ddone_at = -1; idone_at = -1;
      nfi = 0; nfd = 0; blow = -1; seen_busy = 0;
      for (int k = 0; k < 45 && blow < 0; k++) begin
        tick();
        rel = cyc - 1 - t0;
        if (obs.en && first_addr < 0) begin first_addr = int'(obs.addr); first_wr = int'(obs.wr); end
        if (obs.ddn) begin ddone_at = rel; d_req = 1'b0; end
        if (obs.idn) begin idone_at = rel; i_req = 1'b0; end
        nfi += int'(obs.ifv);
        nfd += int'(obs.dfv);
        if (obs.busy) seen_busy = 1;
        else if (seen_busy && rel > 0) blow = rel;
      end
      cmp($sformatf("vec%0d first_addr", v), 64'(first_addr), 64'(tbl[v].e_first_addr));
      cmp($sformatf("vec%0d first_wr", v), 64'(first_wr), 64'(tbl[v].e_first_wr));
      cmp($sformatf("vec%0d d_done_cycle", v), 64'(ddone_at), 64'(tbl[v].e_ddone));
      cmp($sformatf("vec%0d i_done_cycle", v), 64'(idone_at), 64'(tbl[v].e_idone));
      cmp($sformatf("vec%0d i_fill_count", v), 64'(nfi), 64'(tbl[v].e_nfi));
      cmp($sformatf("vec%0d d_fill_count", v), 64'(nfd), 64'(tbl[v].e_nfd));
      cmp($sformatf("vec%0d busy_low_cycle", v), 64'(blow), 64'(tbl[v].e_blow));
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      repeat (2) tick();
    end

    // Spurious read-valid while idle.
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      spur = (k < 3);
      spur_d = 16'($urandom);
      tick();
      cnt += int'(obs.ifv) + int'(obs.dfv) + int'(obs.busy);
    end
    spur = 1'b0;
    cmp("spurious idle activity", 64'(cnt), 64'h0);

    // Reset in the middle of a fill, then a clean restart.
    i_req = 1'b1; i_addr = 16'h1236;
    cnt = 0;
    for (int k = 0; k < 20 && !(obs.ifv && obs.fword == 3'd2); k++) tick();
    cmp("fill word 2 reached", 64'(obs.ifv && obs.fword == 3'd2), 64'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; i_req = 1'b0;
    tick();
    cmp("outputs after mid-fill reset", 64'(obs), 64'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      cnt += int'(obs.idn) + int'(obs.ifv) + int'(obs.busy);
    end
    cmp("no done after reset", 64'(cnt), 64'h0);
    i_req = 1'b1; i_addr = 16'h5678;
    t0 = cyc; first_wr = -1; idone_at = -1;
    for (int k = 0; k < 20 && idone_at < 0; k++) begin
      tick();
      rel = cyc - 1 - t0;
      if (obs.ifv && first_wr < 0) first_wr = int'(obs.fword);
      if (obs.idn) begin idone_at = rel; i_req = 1'b0; end
    end
    cmp("restart first fill_word", 64'(first_wr), 64'h0);
    cmp("restart i_done cycle", 64'(idone_at), 64'd13);
    repeat (3) tick();

    // Random traffic against the timeline model.
    for (int k = 0; k < 700; k++) begin
      tick();
      if (obs.ddn) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 9) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (obs.idn) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 9) == 0) begin
        i_req = 1'b1; i_addr = 16'($urandom);
      end
      spur = !in_fill(cur, cyc) && !in_fill(prev, cyc) && $urandom_range(0, 4) == 0;
      spur_d = 16'($urandom);
    end
    spur = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (obs.ddn) d_req = 1'b0;
      if (obs.idn) i_req = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
